mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_pkg.sv | 56 +++++
 rtl/mc_decode.sv | 32 +++
 rtl/mc_controller.sv | 166 ++++++++++++++++
 tb/tb_mc_controller.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller:
// FSM states, opcodes, ALU ops, mux selects, instruction classes.
package mc_pkg;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_EXEC_R   = 4'd3;
    localparam logic [3:0] S_EXEC_I   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_WB_R     = 4'd8;
    localparam logic [3:0] S_WB_MEM   = 4'd9;
    localparam logic [3:0] S_BRANCH   = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    localparam logic [1:0] PC_ALU = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;
    localparam logic [1:0] SRCB_OFS = 2'b11;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_JMP,
        CLS_HALT
    } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Opcode decoder: instruction class, ALU op, illegal flag.
// Ports: opcode in; cls, alu_op, illegal out (combinational).
module mc_decode
    import mc_pkg::*;
(
    input  logic [3:0] opcode,
    output cls_t       cls,
    output logic [2:0] alu_op,
    output logic       illegal
);

    always_comb begin
        cls     = CLS_HALT;
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OP_ADD:  begin cls = CLS_R; alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CLS_R; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CLS_R; alu_op = ALU_AND; end
            OP_OR:   begin cls = CLS_R; alu_op = ALU_OR;  end
            OP_SLT:  begin cls = CLS_R; alu_op = ALU_SLT; end
            OP_ADDI: cls = CLS_I;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_JMP:  cls = CLS_JMP;
            OP_HALT: cls = CLS_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle processor control FSM with retired-instruction counter.
// Ports: clk, rst, run, opcode, alu_zero, mem_ready in; datapath controls, busy/halted/illegal/instr_count out.
module mc_controller
    import mc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [3:0]       opcode,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    logic [3:0] state;
    logic [3:0] state_nx;
    cls_t       cls_q;
    logic [2:0] aop_q;
    logic       ill_q;
    cls_t       dec_cls;
    logic [2:0] dec_aop;
    logic       dec_ill;
    logic       retire;

    mc_decode u_dec (
        .opcode  (opcode),
        .cls     (dec_cls),
        .alu_op  (dec_aop),
        .illegal (dec_ill)
    );

    // Last cycle of every instruction; MEM_WR only once the write lands.
    assign retire = (state == S_WB_R) || (state == S_WB_MEM) ||
                    (state == S_BRANCH) || (state == S_JUMP) ||
                    ((state == S_MEM_WR) && mem_ready);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (run) state_nx = S_FETCH;
            S_FETCH:    if (mem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                if (dec_ill) state_nx = S_HALT;
                else begin
                    case (dec_cls)
                        CLS_R:   state_nx = S_EXEC_R;
                        CLS_I:   state_nx = S_EXEC_I;
                        CLS_LW,
                        CLS_SW:  state_nx = S_MEM_ADDR;
                        CLS_BEQ: state_nx = S_BRANCH;
                        CLS_JMP: state_nx = S_JUMP;
                        default: state_nx = S_HALT;
                    endcase
                end
            end
            S_EXEC_R:   state_nx = S_WB_R;
            S_EXEC_I:   state_nx = S_WB_R;
            S_MEM_ADDR: state_nx = (cls_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_nx = S_WB_MEM;
            S_HALT:     state_nx = S_HALT;
            default:    state_nx = state;
        endcase
        if (retire) state_nx = run ? S_FETCH : S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cls_q       <= CLS_HALT;
            aop_q       <= ALU_ADD;
            ill_q       <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_nx;
            // Latch the decode so later states depend only on registered state.
            if (state == S_DECODE) begin
                cls_q <= dec_cls;
                aop_q <= dec_aop;
                if (dec_ill) ill_q <= 1'b1;
            end
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_OFS;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = aop_q;
            end
            S_EXEC_I,
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_WB_R: begin
                reg_write = 1'b1;
                reg_dst   = (cls_q == CLS_R);
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = PC_BR;
                pc_write  = alu_zero;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_JMP;
            end
            default: ;
        endcase
    end

    assign halted  = (state == S_HALT);
    assign busy    = (state != S_IDLE) && (state != S_HALT);
    assign illegal = ill_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed vector bench for mc_controller.
// Ports: none; drives both a CNT_W=16 and a CNT_W=4 instance.
module tb_mc_controller;

    typedef struct {
        logic        rst;
        logic        run;
        logic [3:0]  op;
        logic        az;
        logic        rdy;
        logic [15:0] ctrl;
        logic        busy;
        logic        hlt;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, run, alu_zero, mem_ready;
    logic [3:0]  opcode;
    logic        pc_write, ir_write, iord, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
    logic        busy, halted, illegal;
    logic [15:0] instr_count;

    logic        rst4, run4, az4, rdy4;
    logic [3:0]  op4;
    logic        pw4, irw4, iord4, mr4, mw4, rw4, rd4, m2r4, asa4;
    logic [1:0]  asb4, ps4;
    logic [2:0]  aop4;
    logic        busy4, hlt4, ill4;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;
    vec_t tbl[$];

    mc_controller #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .busy(busy), .halted(halted), .illegal(illegal),
        .instr_count(instr_count)
    );

    mc_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst4), .run(run4), .opcode(op4),
        .alu_zero(az4), .mem_ready(rdy4),
        .pc_write(pw4), .ir_write(irw4), .iord(iord4),
        .mem_read(mr4), .mem_write(mw4),
        .reg_write(rw4), .reg_dst(rd4),
        .mem_to_reg(m2r4), .alu_src_a(asa4),
        .alu_src_b(asb4), .alu_op(aop4), .pc_src(ps4),
        .busy(busy4), .halted(hlt4), .illegal(ill4),
        .instr_count(cnt4)
    );

    function automatic logic [15:0] c(
        bit pw, bit irw, bit io, bit mr, bit mw, bit rw, bit rd,
        bit m2r, bit asa, logic [1:0] asb, logic [2:0] aop,
        logic [1:0] ps);
        return {pw, irw, io, mr, mw, rw, rd, m2r, asa, asb, aop, ps};
    endfunction

    function automatic logic [15:0] fetch(bit r);
        return c(r, r, 0, 1, 0, 0, 0, 0, 0, 2'b01, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] dec();
        return c(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] exr(logic [2:0] a);
        return c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, a, 2'b00);
    endfunction
    function automatic logic [15:0] exi();
        return c(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] wbr(bit d);
        return c(0, 0, 0, 0, 0, 1, d, 0, 0, 2'b00, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] mrd();
        return c(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] wbm();
        return c(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] mwr();
        return c(0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 3'd0, 2'b00);
    endfunction
    function automatic logic [15:0] br(bit z);
        return c(z, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'd1, 2'b01);
    endfunction
    function automatic logic [15:0] jmp();
        return c(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'd0, 2'b10);
    endfunction

    task automatic add(bit r, bit rn, logic [3:0] op, bit z, bit rdy,
                       logic [15:0] ct, bit b, bit h, bit il,
                       logic [15:0] n);
        vec_t v;
        v.rst = r; v.run = rn; v.op = op; v.az = z; v.rdy = rdy;
        v.ctrl = ct; v.busy = b; v.hlt = h; v.ill = il; v.cnt = n;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] act_c;
        logic [2:0]  act_s;
        rst = 1'b1; run = 1'b0; opcode = 4'h0;
        alu_zero = 1'b0; mem_ready = 1'b0;
        rst4 = 1'b1; run4 = 1'b0; op4 = 4'h0; az4 = 1'b0; rdy4 = 1'b1;

        // R-type ADD, SUB
        add(0,1,4'h0,0,1, 16'h0,   0,0,0, 0);
        add(0,1,4'h0,0,1, fetch(1),1,0,0, 0);
        add(0,1,4'h0,0,1, dec(),   1,0,0, 0);
        add(0,1,4'h0,0,1, exr(0),  1,0,0, 0);
        add(0,1,4'h0,0,1, wbr(1),  1,0,0, 0);
        add(0,1,4'h1,0,1, fetch(1),1,0,0, 1);
        add(0,1,4'h1,0,1, dec(),   1,0,0, 1);
        add(0,1,4'h1,0,1, exr(1),  1,0,0, 1);
        add(0,1,4'h1,0,1, wbr(1),  1,0,0, 1);
        // ADDI
        add(0,1,4'h5,0,1, fetch(1),1,0,0, 2);
        add(0,1,4'h5,0,1, dec(),   1,0,0, 2);
        add(0,1,4'h5,0,1, exi(),   1,0,0, 2);
        add(0,1,4'h5,0,1, wbr(0),  1,0,0, 2);
        // SW, no wait
        add(0,1,4'h7,0,1, fetch(1),1,0,0, 3);
        add(0,1,4'h7,0,1, dec(),   1,0,0, 3);
        add(0,1,4'h7,0,1, exi(),   1,0,0, 3);
        add(0,1,4'h7,0,1, mwr(),   1,0,0, 3);
        // JMP
        add(0,1,4'h9,0,1, fetch(1),1,0,0, 4);
        add(0,1,4'h9,0,1, dec(),   1,0,0, 4);
        add(0,1,4'h9,0,1, jmp(),   1,0,0, 4);
        // SLT with run dropped in EXEC_R
        add(0,1,4'h4,0,1, fetch(1),1,0,0, 5);
        add(0,1,4'h4,0,1, dec(),   1,0,0, 5);
        add(0,0,4'h4,0,1, exr(4),  1,0,0, 5);
        add(0,0,4'h4,0,1, wbr(1),  1,0,0, 5);
        add(0,0,4'h4,0,1, 16'h0,   0,0,0, 6);
        // LW with three wait cycles
        add(0,1,4'h6,0,1, 16'h0,   0,0,0, 6);
        add(0,1,4'h6,0,1, fetch(1),1,0,0, 6);
        add(0,1,4'h6,0,1, dec(),   1,0,0, 6);
        add(0,1,4'h6,0,1, exi(),   1,0,0, 6);
        add(0,1,4'h6,0,0, mrd(),   1,0,0, 6);
        add(0,1,4'h6,0,0, mrd(),   1,0,0, 6);
        add(0,1,4'h6,0,0, mrd(),   1,0,0, 6);
        add(0,1,4'h6,0,1, mrd(),   1,0,0, 6);
        add(0,1,4'h6,0,1, wbm(),   1,0,0, 6);
        // BEQ taken then not taken
        add(0,1,4'h8,1,1, fetch(1),1,0,0, 7);
        add(0,1,4'h8,1,1, dec(),   1,0,0, 7);
        add(0,1,4'h8,1,1, br(1),   1,0,0, 7);
        add(0,1,4'h8,0,1, fetch(1),1,0,0, 8);
        add(0,1,4'h8,0,1, dec(),   1,0,0, 8);
        add(0,1,4'h8,0,1, br(0),   1,0,0, 8);
        // SW with fetch and write waits
        add(0,1,4'h7,0,0, fetch(0),1,0,0, 9);
        add(0,1,4'h7,0,1, fetch(1),1,0,0, 9);
        add(0,1,4'h7,0,1, dec(),   1,0,0, 9);
        add(0,1,4'h7,0,1, exi(),   1,0,0, 9);
        add(0,1,4'h7,0,0, mwr(),   1,0,0, 9);
        add(0,1,4'h7,0,1, mwr(),   1,0,0, 9);
        // illegal opcode B
        add(0,1,4'hB,0,1, fetch(1),1,0,0, 10);
        add(0,1,4'hB,0,1, dec(),   1,0,0, 10);
        add(0,1,4'hB,0,1, 16'h0,   0,1,1, 10);
        add(0,0,4'hB,0,1, 16'h0,   0,1,1, 10);
        add(1,1,4'hB,0,1, 16'h0,   0,1,1, 10);
        // legal HALT
        add(0,1,4'hF,0,1, 16'h0,   0,0,0, 0);
        add(0,1,4'hF,0,1, fetch(1),1,0,0, 0);
        add(0,1,4'hF,0,1, dec(),   1,0,0, 0);
        add(0,1,4'hF,0,1, 16'h0,   0,1,0, 0);
        add(1,0,4'hF,0,1, 16'h0,   0,1,0, 0);
        // reset during fetch wait
        add(0,1,4'h0,0,0, 16'h0,   0,0,0, 0);
        add(1,1,4'h0,0,0, fetch(0),1,0,0, 0);
        add(0,0,4'h0,0,0, 16'h0,   0,0,0, 0);
        // AND, OR
        add(0,1,4'h2,0,1, 16'h0,   0,0,0, 0);
        add(0,1,4'h2,0,1, fetch(1),1,0,0, 0);
        add(0,1,4'h2,0,1, dec(),   1,0,0, 0);
        add(0,1,4'h2,0,1, exr(2),  1,0,0, 0);
        add(0,1,4'h2,0,1, wbr(1),  1,0,0, 0);
        add(0,1,4'h3,0,1, fetch(1),1,0,0, 1);
        add(0,1,4'h3,0,1, dec(),   1,0,0, 1);
        add(0,1,4'h3,0,1, exr(3),  1,0,0, 1);
        add(0,0,4'h3,0,1, wbr(1),  1,0,0, 1);
        add(0,0,4'h3,0,1, 16'h0,   0,0,0, 2);
        // reset during memory-read wait
        add(0,1,4'h6,0,1, 16'h0,   0,0,0, 2);
        add(0,1,4'h6,0,1, fetch(1),1,0,0, 2);
        add(0,1,4'h6,0,1, dec(),   1,0,0, 2);
        add(0,1,4'h6,0,1, exi(),   1,0,0, 2);
        add(1,1,4'h6,0,0, mrd(),   1,0,0, 2);
        add(0,0,4'h6,0,0, 16'h0,   0,0,0, 0);

        repeat (2) @(posedge clk);
        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; run = tbl[i].run; opcode = tbl[i].op;
            alu_zero = tbl[i].az; mem_ready = tbl[i].rdy;
            #1;
            act_c = {pc_write, ir_write, iord, mem_read, mem_write,
                     reg_write, reg_dst, mem_to_reg, alu_src_a,
                     alu_src_b, alu_op, pc_src};
            act_s = {busy, halted, illegal};
            checks++;
            if (act_c !== tbl[i].ctrl ||
                act_s !== {tbl[i].busy, tbl[i].hlt, tbl[i].ill} ||
                instr_count !== tbl[i].cnt) begin
                errors++;
                $display("FAIL row%0d: ctrl=%h bhi=%b cnt=%0d, want ctrl=%h bhi=%b cnt=%0d",
                         i, act_c, act_s, instr_count, tbl[i].ctrl,
                         {tbl[i].busy, tbl[i].hlt, tbl[i].ill}, tbl[i].cnt);
            end
        end

        // CNT_W=4 instance: 16 back-to-back ADDs wrap the counter to 0.
        @(negedge clk);
        rst4 = 1'b0; run4 = 1'b1; op4 = 4'h0; rdy4 = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            repeat (4) @(negedge clk);
            #1;
            checks++;
            if (cnt4 !== 4'(k)) begin
                errors++;
                $display("FAIL wrap k=%0d: count=%0d, want %0d",
                         k, cnt4, 4'(k));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
